// File: rtl/alu_pipe_param.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides.
// A one-bit carry register (cr) chains multi-word ADDC/SUBB sequences.
module alu_pipe_param #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_ADD  = 3'b011,
    OP_SUB  = 3'b100,
    OP_ADDC = 3'b101,
    OP_SUBB = 3'b110,
    OP_CMP  = 3'b111
  } op_e;

  op_e op;
  assign op = op_e'(sel);

  logic             cr;
  logic             s1v;
  logic [WIDTH-1:0] s1_o;
  logic             s1_c, s1_z, s1_n, s1_v;

  logic s2_en, s1_en, accept;
  assign s2_en    = !out_valid || out_ready;
  assign s1_en    = !s1v || s2_en;
  assign in_ready = s1_en;
  assign accept   = in_valid && in_ready;

  logic             cin, bin, ld_cr;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] r_o;
  logic             r_c, r_z, r_n, r_v;

  assign cin  = (op == OP_ADDC) && cr;
  assign bin  = (op == OP_SUBB) && cr;
  assign sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    r_o   = '0;
    r_c   = 1'b0;
    r_v   = 1'b0;
    ld_cr = 1'b0;
    unique case (op)
      OP_AND: r_o = a & b;
      OP_OR:  r_o = a | b;
      OP_XOR: r_o = a ^ b;
      OP_ADD, OP_ADDC: begin
        r_o   = sum[MSB:0];
        r_c   = sum[WIDTH];
        r_v   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
        ld_cr = 1'b1;
      end
      OP_SUB, OP_SUBB: begin
        r_o   = diff[MSB:0];
        r_c   = diff[WIDTH];
        r_v   = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
        ld_cr = 1'b1;
      end
      OP_CMP: begin
        r_o = a;
        r_c = diff[WIDTH];
        r_v = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      default: r_o = '0;
    endcase
    r_z = (r_o == '0);
    r_n = r_o[MSB];
    // CMP reports the flags of the difference while passing A through.
    if (op == OP_CMP) begin
      r_z = (diff[MSB:0] == '0);
      r_n = diff[MSB];
    end
  end

  // NOTE: state uses non-blocking assignments so S2 captures the pre-edge S1 contents when both advance together.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: data registers are reset too, because O and the flags must read zero after reset.
      cr        <= 1'b0;
      s1v       <= 1'b0;
      s1_o      <= '0;
      s1_c      <= 1'b0;
      s1_z      <= 1'b0;
      s1_n      <= 1'b0;
      s1_v      <= 1'b0;
      out_valid <= 1'b0;
      o         <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (accept && ld_cr) cr <= r_c;
      if (s1_en) begin
        s1v <= accept;
        if (accept) begin
          s1_o <= r_o;
          s1_c <= r_c;
          s1_z <= r_z;
          s1_n <= r_n;
          s1_v <= r_v;
        end
      end
      if (s2_en) begin
        out_valid <= s1v;
        if (s1v) begin
          o     <= s1_o;
          carry <= s1_c;
          zero  <= s1_z;
          neg   <= s1_n;
          ovf   <= s1_v;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe_param.sv
// Directed and short random stimulus for alu_pipe_param (WIDTH=12).
// Expected results come from an integer model and flow through a scoreboard queue.
module tb_alu_pipe_param;

  localparam int W = 12;

  typedef struct packed {
    logic [W-1:0] o;
    logic         c, z, n, v;
  } exp_t;

  logic         clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]   sel;
  logic [W-1:0] a, b, o;
  logic         carry, zero, neg, ovf;

  int   errors = 0;
  int   checks = 0;
  exp_t scb[$];
  logic mcr = 1'b0;
  logic rand_done = 1'b0;

  alu_pipe_param #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .o(o), .carry(carry), .zero(zero), .neg(neg), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sgn(input int u);
    return (u >= 2048) ? u - 4096 : u;
  endfunction

  function automatic exp_t model(input logic [2:0] s, input int ua, input int ub,
                                 input logic cr_in, output logic cr_out);
    exp_t m;
    int   r, sr, k;
    m      = '0;
    cr_out = cr_in;
    k      = 0;
    case (s)
      3'd0: m.o = W'(ua & ub);
      3'd1: m.o = W'(ua | ub);
      3'd2: m.o = W'(ua ^ ub);
      3'd3, 3'd5: begin
        k      = (s == 3'd5 && cr_in) ? 1 : 0;
        r      = ua + ub + k;
        sr     = sgn(ua) + sgn(ub) + k;
        m.o    = W'(r);
        m.c    = (r > 4095);
        m.v    = (sr > 2047) || (sr < -2048);
        cr_out = m.c;
      end
      3'd4, 3'd6: begin
        k      = (s == 3'd6 && cr_in) ? 1 : 0;
        r      = ua - ub - k;
        sr     = sgn(ua) - sgn(ub) - k;
        m.o    = W'(r);
        m.c    = (r < 0);
        m.v    = (sr > 2047) || (sr < -2048);
        cr_out = m.c;
      end
      default: begin
        r   = ua - ub;
        sr  = sgn(ua) - sgn(ub);
        m.o = W'(ua);
        m.c = (r < 0);
        m.v = (sr > 2047) || (sr < -2048);
      end
    endcase
    if (s == 3'd7) begin
      m.z = (r == 0);
      m.n = ((r & 4095) >= 2048);
    end else begin
      m.z = (m.o == '0);
      m.n = m.o[W-1];
    end
    return m;
  endfunction

  // Drive one op, wait (bounded) for acceptance, and push its expected result.
  task automatic issue(input logic [2:0] s, input logic [W-1:0] x, input logic [W-1:0] y);
    int   n;
    logic ncr;
    in_valid = 1'b1;
    sel = s; a = x; b = y;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        check("in_ready_timeout", 64'(in_ready), 1);
        break;
      end
    end
    if (in_ready) begin
      scb.push_back(model(s, int'(x), int'(y), mcr, ncr));
      mcr = ncr;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (scb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    check("drain_timeout", 64'(scb.size()), 0);
  endtask

  // Scoreboard consumer: compare each result the consumer actually takes.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (scb.size() == 0) begin
        check("spurious_output", 64'(scb.size()), 1);
      end else begin
        e = scb.pop_front();
        check("o",     64'(o),     64'(e.o));
        check("carry", 64'(carry), 64'(e.c));
        check("zero",  64'(zero),  64'(e.z));
        check("neg",   64'(neg),   64'(e.n));
        check("ovf",   64'(ovf),   64'(e.v));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    sel = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_o",         64'(o),         0);
    check("rst_carry",     64'(carry),     0);
    check("rst_zero",      64'(zero),      0);
    check("rst_neg",       64'(neg),       0);
    check("rst_ovf",       64'(ovf),       0);
    check("rst_in_ready",  64'(in_ready),  1);

    // ADD wrap to zero, with latency check on out_valid.
    issue(3'b011, 12'hFFF, 12'h001);
    check("lat_not_yet", 64'(out_valid), 0);
    @(posedge clk); #1;
    check("lat_valid",   64'(out_valid), 1);
    check("lat_o",       64'(o),         12'h000);
    drain();

    // Back-to-back ADD -> ADDC carry chain.
    issue(3'b011, 12'hFFF, 12'h001);
    issue(3'b101, 12'h000, 12'h000);
    drain();

    // SUB borrow and ADD signed overflow.
    issue(3'b100, 12'h005, 12'h007);
    issue(3'b011, 12'h7FF, 12'h001);
    drain();

    // CMP leaves CR alone.
    issue(3'b011, 12'hFFF, 12'h001);
    issue(3'b111, 12'h123, 12'h123);
    issue(3'b101, 12'h000, 12'h000);
    drain();

    // Consumer stalls five cycles while four ops are offered.
    out_ready = 1'b0;
    fork
      begin
        issue(3'b011, 12'h100, 12'h001);
        issue(3'b010, 12'hF0F, 12'h0FF);
        issue(3'b001, 12'h00A, 12'h050);
        issue(3'b000, 12'hABC, 12'h0F0);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        check("stall_in_ready",  64'(in_ready),   0);
        check("stall_out_valid", 64'(out_valid),  1);
        check("stall_o_held",    64'(o),          12'h101);
        check("stall_accepted",  64'(scb.size()), 2);
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two ops in flight discards them and clears CR.
    out_ready = 1'b0;
    issue(3'b011, 12'hFFF, 12'h001);
    issue(3'b011, 12'h010, 12'h020);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    scb.delete();
    mcr = 1'b0;
    check("rst2_out_valid", 64'(out_valid), 0);
    check("rst2_o",         64'(o),         0);
    check("rst2_in_ready",  64'(in_ready),  1);
    out_ready = 1'b1;
    issue(3'b101, 12'h000, 12'h000);
    drain();

    // Random ops against a randomly stalling consumer.
    fork
      begin
        for (int i = 0; i < 24; i++)
          issue(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    check("scb_empty_end", 64'(scb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
